// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll engine: FSM state codes, the default
// face table and the helpers that turn a one-hot die select into face/mask.
package dice_pkg;

    // Upper bound on die types the helper functions can handle.
    localparam int DIE_MAX = 16;

    // FSM state codes.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Default face table, entry 0 in the LSB byte (D4 .. D20).
    localparam logic [47:0] DEF_FACE_LIST = {8'd20, 8'd12, 8'd10, 8'd8, 8'd6, 8'd4};

    // Default abort threshold for consecutive rejected samples.
    localparam int DEF_MAX_REJECT = 16;

    // Ceiling log2 of a face count (valid for 1..128): the mask width needed
    // so that every face value 0..v-1 is representable.
    function automatic logic [3:0] clog2_face(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if ((9'd1 << i) < {1'b0, v}) begin
                n = 4'(i + 1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Face count selected by a one-hot die select.
    function automatic logic [7:0] face_of(input logic [DIE_MAX*8-1:0] list,
                                           input logic [DIE_MAX-1:0]   sel);
        logic [7:0] f;
        f = 8'd0;
        for (int i = 0; i < DIE_MAX; i++) begin
            if (sel[i]) begin
                f = list[i*8 +: 8];
            end else begin
                f = f;
            end
        end
        return f;
    endfunction

    // True when exactly one bit of the select is set.
    function automatic logic is_onehot(input logic [DIE_MAX-1:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < DIE_MAX; i++) begin
            n = n + 5'(v[i]);
        end
        return (n == 5'd1);
    endfunction

endpackage

// File: rtl/die_sampler.sv
// Mask-and-reject sampler: masks a raw random word to the die's bit width,
// accepts it when below the face count and counts consecutive rejects,
// flagging an abort when the reject limit is hit.
module die_sampler
    import dice_pkg::*;
#(
    parameter int RAND_W     = 7,
    parameter int MAX_REJECT = DEF_MAX_REJECT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              active,
    input  logic [RAND_W-1:0] rand_word,
    input  logic              rand_valid,
    input  logic [7:0]        face,
    input  logic [3:0]        mask_w,
    output logic              accept,
    output logic [7:0]        value,
    output logic              abort
);

    localparam int CW = $clog2(MAX_REJECT + 1);

    logic [CW-1:0]     reject_cnt;
    logic [RAND_W-1:0] mask;
    logic [RAND_W-1:0] r;
    logic              hit;
    logic              in_range;
    logic              reject;

    // Mask the sample, compare against the face count and decide accept/reject.
    always_comb begin
        mask     = ~({RAND_W{1'b1}} << mask_w);
        r        = rand_word & mask;
        hit      = active && rand_valid;
        in_range = (16'(r) < 16'(face));
        accept   = hit && in_range;
        reject   = hit && !in_range;
        value    = 8'(r) + 8'd1;
        abort    = reject && (reject_cnt == CW'(MAX_REJECT - 1));
    end

    // Consecutive-reject counter; restarts on new request, accept or abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            reject_cnt <= '0;
        end else if (clear || accept || abort) begin
            reject_cnt <= '0;
        end else if (reject) begin
            reject_cnt <= reject_cnt + CW'(1);
        end else begin
            reject_cnt <= reject_cnt;
        end
    end

endmodule

// File: rtl/dice_roll_engine.sv
// Dice roll engine: accepts a roll request (die type + count), draws random
// words until enough unbiased die values are accepted, sums them and hands
// the total to the downstream stage over a valid/ready handshake.
module dice_roll_engine
    import dice_pkg::*;
#(
    parameter int                     NUM_DIE    = 6,
    parameter logic [NUM_DIE*8-1:0]   FACE_LIST  = DEF_FACE_LIST,
    parameter int                     RAND_W     = 7,
    parameter int                     MAX_COUNT  = 4,
    parameter int                     CNT_W      = 3,
    parameter int                     SUM_W      = 7,
    parameter int                     MAX_REJECT = DEF_MAX_REJECT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [NUM_DIE-1:0] i_die_sel,
    input  logic [CNT_W-1:0]   i_count,
    output logic               o_busy,
    output logic               o_rand_req,
    input  logic [RAND_W-1:0]  i_rand,
    input  logic               i_rand_valid,
    output logic [7:0]         o_die_roll,
    output logic               o_die_strobe,
    output logic [SUM_W-1:0]   o_result,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_error
);

    logic [1:0]             state;
    logic [7:0]             face;
    logic [3:0]             mask_w;
    logic [CNT_W-1:0]       remaining;
    logic [SUM_W-1:0]       sum;
    logic [SUM_W-1:0]       sum_next;
    logic [DIE_MAX*8-1:0]   list_ext;
    logic [DIE_MAX-1:0]     sel_ext;
    logic [7:0]             sel_face;
    logic                   req_ok;
    logic                   accept;
    logic                   abort;
    logic [7:0]             value;

    // Decode the incoming request and the running sum after this sample.
    always_comb begin
        list_ext = (DIE_MAX*8)'(FACE_LIST);
        sel_ext  = DIE_MAX'(i_die_sel);
        sel_face = face_of(list_ext, sel_ext);
        req_ok   = (state == ST_IDLE) && i_req && is_onehot(sel_ext)
                   && (i_count >= CNT_W'(1)) && (i_count <= CNT_W'(MAX_COUNT));
        sum_next = sum + SUM_W'(value);
    end

    die_sampler #(
        .RAND_W     (RAND_W),
        .MAX_REJECT (MAX_REJECT)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .clear      (req_ok),
        .active     (state == ST_DRAW),
        .rand_word  (i_rand),
        .rand_valid (i_rand_valid),
        .face       (face),
        .mask_w     (mask_w),
        .accept     (accept),
        .value      (value),
        .abort      (abort)
    );

    // Roll FSM with count/sum bookkeeping and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            face         <= 8'd0;
            mask_w       <= 4'd0;
            remaining    <= '0;
            sum          <= '0;
            o_busy       <= 1'b0;
            o_rand_req   <= 1'b0;
            o_die_roll   <= 8'd0;
            o_die_strobe <= 1'b0;
            o_result     <= '0;
            o_valid      <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_die_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_ok) begin
                        face       <= sel_face;
                        mask_w     <= clog2_face(sel_face);
                        remaining  <= i_count;
                        sum        <= '0;
                        o_error    <= 1'b0;
                        o_busy     <= 1'b1;
                        o_rand_req <= 1'b1;
                        state      <= ST_DRAW;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAW: begin
                    if (accept) begin
                        o_die_roll   <= value;
                        o_die_strobe <= 1'b1;
                        sum          <= sum_next;
                        remaining    <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            o_result   <= sum_next;
                            o_valid    <= 1'b1;
                            o_rand_req <= 1'b0;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_DRAW;
                        end
                    end else if (abort) begin
                        o_error    <= 1'b1;
                        o_busy     <= 1'b0;
                        o_rand_req <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        state <= ST_DRAW;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    o_valid    <= 1'b0;
                    o_busy     <= 1'b0;
                    o_rand_req <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_roll_engine.sv
// Directed self-checking bench for dice_roll_engine.
module tb_dice_roll_engine;

    logic       clk;
    logic       reset;
    logic       i_req;
    logic [5:0] i_die_sel;
    logic [2:0] i_count;
    logic       o_busy;
    logic       o_rand_req;
    logic [6:0] i_rand;
    logic       i_rand_valid;
    logic [7:0] o_die_roll;
    logic       o_die_strobe;
    logic [6:0] o_result;
    logic       o_valid;
    logic       i_ready;
    logic       o_error;

    int errors = 0;
    int checks = 0;
    logic seen_valid;

    dice_roll_engine dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_die_sel    (i_die_sel),
        .i_count      (i_count),
        .o_busy       (o_busy),
        .o_rand_req   (o_rand_req),
        .i_rand       (i_rand),
        .i_rand_valid (i_rand_valid),
        .o_die_roll   (o_die_roll),
        .o_die_strobe (o_die_strobe),
        .o_result     (o_result),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_error      (o_error)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle.
    task automatic start(input logic [5:0] sel, input logic [2:0] cnt);
        i_req     = 1'b1;
        i_die_sel = sel;
        i_count   = cnt;
        tick();
        i_req     = 1'b0;
    endtask

    // Present one valid random word for one cycle.
    task automatic feed(input logic [6:0] v);
        i_rand       = v;
        i_rand_valid = 1'b1;
        tick();
        i_rand_valid = 1'b0;
    endtask

    // Complete the output handshake.
    task automatic drain();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; i_die_sel = 6'd0; i_count = 3'd0;
        i_rand = 7'd0; i_rand_valid = 1'b0; i_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_value("rst_busy", 32'(o_busy), 32'd0);
        check_value("rst_valid", 32'(o_valid), 32'd0);
        check_value("rst_result", 32'(o_result), 32'd0);
        check_value("rst_rand_req", 32'(o_rand_req), 32'd0);
        check_value("rst_error", 32'(o_error), 32'd0);

        // D6, count 1, r=5 -> 6
        i_rand = 7'h05; i_rand_valid = 1'b1;
        start(6'b000010, 3'd1);
        check_value("d6_busy", 32'(o_busy), 32'd1);
        check_value("d6_rand_req", 32'(o_rand_req), 32'd1);
        tick();
        i_rand_valid = 1'b0;
        check_value("d6_strobe", 32'(o_die_strobe), 32'd1);
        check_value("d6_roll", 32'(o_die_roll), 32'd6);
        check_value("d6_valid", 32'(o_valid), 32'd1);
        check_value("d6_result", 32'(o_result), 32'd6);
        check_value("d6_rand_req_off", 32'(o_rand_req), 32'd0);
        tick();
        check_value("d6_hold_valid", 32'(o_valid), 32'd1);
        check_value("d6_strobe_pulse", 32'(o_die_strobe), 32'd0);
        drain();
        check_value("d6_xfer_valid", 32'(o_valid), 32'd0);
        check_value("d6_xfer_busy", 32'(o_busy), 32'd0);
        check_value("d6_result_hold", 32'(o_result), 32'd6);

        // D20, count 3: 0x13, 0x00, 0x0A -> 20, 1, 11 = 32
        start(6'b100000, 3'd3);
        feed(7'h13);
        check_value("d20_roll0", 32'(o_die_roll), 32'd20);
        check_value("d20_strobe0", 32'(o_die_strobe), 32'd1);
        feed(7'h00);
        check_value("d20_roll1", 32'(o_die_roll), 32'd1);
        check_value("d20_valid_early", 32'(o_valid), 32'd0);
        feed(7'h0A);
        check_value("d20_roll2", 32'(o_die_roll), 32'd11);
        check_value("d20_valid", 32'(o_valid), 32'd1);
        check_value("d20_result", 32'(o_result), 32'd32);
        drain();

        // D10, count 1: 15 and 12 rejected, 3 -> 4
        start(6'b001000, 3'd1);
        feed(7'h0F);
        check_value("d10_rej0_strobe", 32'(o_die_strobe), 32'd0);
        feed(7'h0C);
        check_value("d10_rej1_strobe", 32'(o_die_strobe), 32'd0);
        check_value("d10_rej1_busy", 32'(o_busy), 32'd1);
        feed(7'h03);
        check_value("d10_roll", 32'(o_die_roll), 32'd4);
        check_value("d10_valid", 32'(o_valid), 32'd1);
        check_value("d10_result", 32'(o_result), 32'd4);
        drain();

        // D12, count 2: 16 consecutive rejects -> abort
        start(6'b010000, 3'd2);
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            feed(7'h7F);
            seen_valid = seen_valid | o_valid;
        end
        check_value("d12_err_early", 32'(o_error), 32'd0);
        check_value("d12_busy_early", 32'(o_busy), 32'd1);
        feed(7'h7F);
        seen_valid = seen_valid | o_valid;
        check_value("d12_error", 32'(o_error), 32'd1);
        check_value("d12_busy", 32'(o_busy), 32'd0);
        check_value("d12_rand_req", 32'(o_rand_req), 32'd0);
        check_value("d12_no_valid", 32'(seen_valid), 32'd0);
        tick();
        check_value("d12_error_sticky", 32'(o_error), 32'd1);

        // D4, count 1: 0x06 masked to 2 -> 3; clears error
        start(6'b000001, 3'd1);
        check_value("d4_error_clr", 32'(o_error), 32'd0);
        feed(7'h06);
        check_value("d4_roll", 32'(o_die_roll), 32'd3);
        check_value("d4_valid", 32'(o_valid), 32'd1);

        // Backpressure: pulses of i_req and random words ignored while held
        i_rand = 7'h01; i_rand_valid = 1'b1;
        i_die_sel = 6'b100000; i_count = 3'd2;
        for (int i = 0; i < 5; i++) begin
            i_req = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            check_value("bp_valid", 32'(o_valid), 32'd1);
            check_value("bp_result", 32'(o_result), 32'd3);
        end
        i_req = 1'b0; i_rand_valid = 1'b0;
        drain();
        check_value("bp_xfer_valid", 32'(o_valid), 32'd0);
        check_value("bp_xfer_busy", 32'(o_busy), 32'd0);
        tick();
        check_value("bp_not_queued", 32'(o_busy), 32'd0);

        // D8, count 4: reset after two accepts
        start(6'b000100, 3'd4);
        feed(7'h01);
        feed(7'h02);
        check_value("d8_roll_pre", 32'(o_die_roll), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_value("mid_rst_busy", 32'(o_busy), 32'd0);
        check_value("mid_rst_rand_req", 32'(o_rand_req), 32'd0);
        check_value("mid_rst_roll", 32'(o_die_roll), 32'd0);
        check_value("mid_rst_result", 32'(o_result), 32'd0);
        check_value("mid_rst_valid", 32'(o_valid), 32'd0);

        // Invalid requests: two-hot select, zero count, count above max
        start(6'b000011, 3'd1);
        check_value("inv_twohot", 32'(o_busy), 32'd0);
        start(6'b000100, 3'd0);
        check_value("inv_cnt0", 32'(o_busy), 32'd0);
        start(6'b000100, 3'd5);
        check_value("inv_cnt5", 32'(o_busy), 32'd0);

        // D8, max count: four 7s -> 8 each, sum 32 from a fresh start
        start(6'b000100, 3'd4);
        check_value("d8max_busy", 32'(o_busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            feed(7'h07);
        end
        check_value("d8max_roll", 32'(o_die_roll), 32'd8);
        check_value("d8max_valid", 32'(o_valid), 32'd1);
        check_value("d8max_result", 32'(o_result), 32'd32);
        drain();
        check_value("d8max_idle", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
